// File: rtl/disp_mux_scan.sv
// ---------------------------------------------------------------------------
// disp_mux_scan
//
// Registered N-channel display source selector. One of NUM_CH packed source
// channels is selected, zero-extended to OUT_W and driven onto the display
// bus one clock after the inputs are sampled. There are three modes:
// manual select, round-robin scan with a DWELL-cycle dwell per channel, and
// freeze.
//
// Optional feature macro: DISP_BLINK_EN
//   When defined, a free-running blink timer toggles a phase every
//   BLINK_CYCLES cycles. While in_blink is high and the phase is 1, out_mux
//   is blanked to zero. out_ch and out_upd are never affected by blinking.
//   When undefined, no blink logic is built and in_blink is ignored.
//
// Ports
//   clk        in   1                 sole clock, rising edge
//   reset      in   1                 synchronous, active-high
//   in_data    in   NUM_CH*DATA_W     channel k at [k*DATA_W +: DATA_W]
//   in_sel     in   SEL_W             manual channel select
//   in_mode    in   1                 0 = manual, 1 = scan
//   in_freeze  in   1                 hold the display
//   in_blink   in   1                 blink request (DISP_BLINK_EN only)
//   out_mux    out  OUT_W             registered display value
//   out_ch     out  SEL_W             channel currently shown
//   out_upd    out  1                 one-cycle pulse when out_ch changes
//
// State table
//   state  | meaning
//   -------+-------------------------------------------------------------
//   MANUAL | channel follows in_sel (out-of-range select holds), dwell = 0
//   SCAN   | dwell counter runs, channel advances every DWELL cycles
//   FROZEN | display, channel and dwell count held, no update pulses
// ---------------------------------------------------------------------------
module disp_mux_scan #(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 16,
    parameter int OUT_W        = 16,
    parameter int DWELL        = 8,
    parameter int BLINK_CYCLES = 4,
    localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_mode,
    input  logic                     in_freeze,
    input  logic                     in_blink,
    output logic [OUT_W-1:0]         out_mux,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_upd
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DW_W-1:0]  LAST_DWELL = DW_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]   NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        FROZEN = 2'd2
    } dispState_t;

    dispState_t state;
    logic [DW_W-1:0] dwellCnt;

    logic [DATA_W-1:0] chan [NUM_CH];
    logic [DW_W-1:0]   scanCnt;
    logic              scanWrap;
    logic              selValid;
    logic [SEL_W-1:0]  manualCh;
    logic [SEL_W-1:0]  scanCh;
    logic [SEL_W-1:0]  nextCh;
    logic [DW_W-1:0]   nextCnt;
    logic [DATA_W-1:0] chData;
    logic [OUT_W-1:0]  nextVal;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            chan[k] = in_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        // MANUAL always parks the dwell count at zero, so entering SCAN from
        // MANUAL starts a fresh dwell; leaving FROZEN keeps the held count.
        scanCnt  = (state == MANUAL) ? '0 : dwellCnt;
        scanWrap = (scanCnt == LAST_DWELL);

        selValid = ({1'b0, in_sel} < NUM_CH_EXT);
        manualCh = selValid ? in_sel : out_ch;

        scanCh = out_ch;
        if (scanWrap) begin
            scanCh = (out_ch == LAST_CH) ? '0 : out_ch + 1'b1;
        end

        nextCh  = in_mode ? scanCh : manualCh;
        nextCnt = '0;
        if (in_mode) begin
            nextCnt = scanWrap ? '0 : scanCnt + 1'b1;
        end

        chData  = chan[nextCh];
        nextVal = '0;
        nextVal[DATA_W-1:0] = chData;
    end

`ifdef DISP_BLINK_EN
    localparam int BC_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BC_W-1:0] LAST_BLINK = BC_W'(BLINK_CYCLES - 1);

    logic [BC_W-1:0]  blinkCnt;
    logic             blinkPhase;
    logic [OUT_W-1:0] heldVal;
    logic             blank;

    // Blanking uses the phase present at the sampling edge, so the first
    // BLINK_CYCLES displayed values after reset are shown unblanked.
    assign blank = in_blink & blinkPhase;
`else
    logic unusedBlink;
    localparam int unusedBlinkCycles = BLINK_CYCLES;
    assign unusedBlink = in_blink;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MANUAL;
            dwellCnt <= '0;
            out_mux  <= '0;
            out_ch   <= '0;
            out_upd  <= 1'b0;
`ifdef DISP_BLINK_EN
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
            heldVal    <= '0;
`endif
        end else begin
`ifdef DISP_BLINK_EN
            // The blink timer keeps running while frozen.
            if (blinkCnt == LAST_BLINK) begin
                blinkCnt   <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                blinkCnt <= blinkCnt + 1'b1;
            end
`endif
            if (in_freeze) begin
                state   <= FROZEN;
                out_upd <= 1'b0;
`ifdef DISP_BLINK_EN
                // The unblanked value is kept separately so a freeze taken
                // during a blanked phase still shows the held value later.
                out_mux <= blank ? '0 : heldVal;
`endif
            end else begin
                state    <= in_mode ? SCAN : MANUAL;
                dwellCnt <= nextCnt;
                out_ch   <= nextCh;
                out_upd  <= (nextCh != out_ch);
`ifdef DISP_BLINK_EN
                heldVal <= nextVal;
                out_mux <= blank ? '0 : nextVal;
`else
                out_mux <= nextVal;
`endif
            end
        end
    end

endmodule
